// File: rtl/mult_div_unit.sv
// Multicycle integer multiply/divide unit producing HI/LO results for
// MIPS mult, multu, div and divu. Multiplication is a radix-2 shift-add on
// operand magnitudes; division is restoring shift-subtract on magnitudes.
// A final fix-up stage restores signs before writing hi/lo.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;     // negate product (mult) or quotient (div)
    logic               neg_r;     // negate remainder: dividend was negative
    logic               dz;        // divide by zero detected at launch

    // acc_hi:acc_lo is the product shift register for multiply and the
    // remainder:quotient shift register for divide; m holds the
    // multiplicand magnitude or the divisor magnitude.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   m;

    // Launch-time operand conditioning (op[0]=0 selects the signed forms)
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_is_zero;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    // The magnitude of MIN is itself, which as an unsigned value is exactly right.
    assign a_mag     = a_neg ? ({WIDTH{1'b0}} - a) : a;
    assign b_mag     = b_neg ? ({WIDTH{1'b0}} - b) : b;
    assign b_is_zero = (b == {WIDTH{1'b0}});

    // Single iteration step for the RUN state
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    // Combinational next value of the shift registers for one iteration
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        mul_sum   = {1'b0, acc_hi} + {1'b0, m};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        // The partial remainder is always below the divisor, so the low
        // WIDTH bits of the difference are exact whenever it fits.
        div_diff  = div_shift[WIDTH-1:0] - m;
        div_fits  = (div_shift >= {1'b0, m});
        if (is_div) begin
            step_hi = div_fits ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_fits};
        end else if (acc_lo[0]) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, acc_hi[WIDTH-1:1]};
            step_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the finished magnitude results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Restore signs: product/quotient by sign(a)^sign(b), remainder by sign(a)
    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        q_fix    = acc_lo;
        r_fix    = acc_hi;
        if (neg_q) begin
            prod_fix = {(2*WIDTH){1'b0}} - {acc_hi, acc_lo};
            q_fix    = {WIDTH{1'b0}} - acc_lo;
        end
        if (neg_r) begin
            r_fix = {WIDTH{1'b0}} - acc_hi;
        end
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            m        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc_hi <= '0;
                        // Multiply: acc_lo = multiplier, m = multiplicand.
                        // Divide:   acc_lo = dividend,   m = divisor.
                        acc_lo <= op[1] ? a_mag : b_mag;
                        m      <= op[1] ? b_mag : a_mag;
                        cnt    <= CNT_W'(WIDTH);
                        busy   <= 1'b1;
                        if (op[1] && b_is_zero) begin
                            dz    <= 1'b1;
                            state <= FIN;
                        end else begin
                            dz    <= 1'b0;
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                    end
                end

                FIN: begin
                    // First FIN cycle writes the result and raises done;
                    // the second (done high) drops busy and returns to IDLE.
                    if (!done) begin
                        done <= 1'b1;
                        if (dz) begin
                            div_zero <= 1'b1;
                        end else if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end else begin
                        done     <= 1'b0;
                        div_zero <= 1'b0;
                        busy     <= 1'b0;
                        dz       <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: WIDTH=32 instance for the main
// vectors plus a WIDTH=8 instance for the narrow signed multiply.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;

    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        s_start;
    logic [1:0]  s_op;
    logic [7:0]  s_a;
    logic [7:0]  s_b;
    logic        s_busy;
    logic        s_done;
    logic        s_div_zero;
    logic [7:0]  s_hi;
    logic [7:0]  s_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (s_start),
        .op       (s_op),
        .a        (s_a),
        .b        (s_b),
        .busy     (s_busy),
        .done     (s_done),
        .div_zero (s_div_zero),
        .hi       (s_hi),
        .lo       (s_lo)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one launch edge, then scramble inputs
    task automatic launch(input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi);
        start = 1'b1;
        op    = o;
        a     = ai;
        b     = bi;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count edges (launch edge is edge 1) until done is seen, bounded
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Full operation: launch, latency, result, then return to idle
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] ai,
                          input logic [31:0] bi, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        launch(o, ai, bi);
        check({tag, "_busy_launch"}, 64'(busy), 64'(1));
        wait_done(1, n);
        check({tag, "_latency"}, 64'(n), 64'(34));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_dz"}, 64'(div_zero), 64'(0));
        check({tag, "_busy_done"}, 64'(busy), 64'(1));
        tick();
        check({tag, "_done_clr"}, 64'(done), 64'(0));
        check({tag, "_busy_clr"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        s_start = 1'b0;
        s_op    = 2'b00;
        s_a     = '0;
        s_b     = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_zero), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;
        tick();

        // -2 * 3 = -6
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        // (2^32-1)^2 = 0xFFFFFFFE_00000001
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        // 7 * -5 = -35
        run_op("mult_mix", 2'b00, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD);
        // -7 / 2 = -3 rem -1
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // MIN / -1 wraps to MIN rem 0
        run_op("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        // 7 / -2 = -3 rem 1 (remainder follows the dividend)
        run_op("div_posneg", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        // Reset during RUN cycle 10 of a multiply discards the result
        launch(2'b00, 32'h0000_0005, 32'h0000_0006);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'(0));

        // divu 100/7 with a stray start pulse at RUN cycle 5
        launch(2'b11, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd3;
        tick();
        start = 1'b0;
        wait_done(6, n);
        check("ign_latency", 64'(n), 64'(34));
        check("ign_hi", 64'(hi), 64'(2));
        check("ign_lo", 64'(lo), 64'(14));
        tick();
        check("ign_idle", 64'(busy), 64'(0));

        // divu 5/0: done+div_zero after the next edge, hi/lo untouched
        launch(2'b11, 32'd5, 32'd0);
        wait_done(1, n);
        check("dz_latency", 64'(n), 64'(2));
        check("dz_flag", 64'(div_zero), 64'(1));
        check("dz_hi", 64'(hi), 64'(2));
        check("dz_lo", 64'(lo), 64'(14));
        tick();
        check("dz_flag_clr", 64'(div_zero), 64'(0));
        check("dz_done_clr", 64'(done), 64'(0));

        // start held high: ignored in FIN, relaunches on first IDLE cycle
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd0;
        tick();
        check("hold_busy0", 64'(busy), 64'(1));
        tick();
        check("hold_done1", 64'(done), 64'(1));
        tick();
        check("hold_idle", 64'(busy), 64'(0));
        tick();
        check("hold_relaunch", 64'(busy), 64'(1));
        start = 1'b0;
        tick();
        check("hold_done2", 64'(done), 64'(1));
        check("hold_dz2", 64'(div_zero), 64'(1));
        check("hold_lo", 64'(lo), 64'(14));
        tick();

        // WIDTH=8: (-128)*(-128) = 0x4000
        s_start = 1'b1;
        s_op    = 2'b00;
        s_a     = 8'h80;
        s_b     = 8'h80;
        tick();
        s_start = 1'b0;
        s_a     = 8'h11;
        s_b     = 8'h22;
        n = 1;
        while (s_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("w8_latency", 64'(n), 64'(10));
        check("w8_hi", 64'(s_hi), 64'(8'h40));
        check("w8_lo", 64'(s_lo), 64'(8'h00));
        tick();
        check("w8_idle", 64'(s_busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
